// File: rtl/headdrop_ctrl_pkg.sv
// Shared definitions for the head-drop request controller.
//   - FSM state encoding (IDLE / REQ / GAP)
//   - default port count and packet-length width
//   - one-hot <-> binary conversion for 4-bit port fields
package headdrop_ctrl_pkg;

    localparam int HD_NPORT_DEF = 4;
    localparam int HD_LEN_W_DEF = 11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Lowest set bit wins if more than one bit is set.
    function automatic logic [3:0] onehot_to_bin(input logic [3:0] oh);
        logic [3:0] b;
        b = '0;
        for (int i = 3; i >= 0; i--) begin
            if (oh[i]) b = 4'(i);
        end
        return b;
    endfunction

    // Indices above 3 yield all zeros.
    function automatic logic [3:0] bin_to_onehot(input logic [3:0] b);
        return 4'b0001 << b;
    endfunction

endpackage

// File: rtl/headdrop_ctrl_rr_pick.sv
// Combinational circular priority picker.
// Searches cand starting at index ptr, wrapping around, and grants the
// first set bit. Shared with the egress scheduler.
// Ports:
//   cand   in  N   request vector
//   ptr    in  PW  index with highest priority this cycle
//   grant  out N   one-hot grant (all zero when nothing requested)
//   valid  out 1   at least one request present
module headdrop_ctrl_rr_pick
    import headdrop_ctrl_pkg::*;
#(
    parameter int N  = HD_NPORT_DEF,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [PW-1:0] sel;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            sel = PW'((int'(ptr) + i) % N);
            if (!valid && cand[sel]) begin
                grant[sel] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/headdrop_ctrl.sv
// Head-drop issuing controller.
// Picks an over-threshold, non-empty queue in round-robin order, asks the
// queue manager to drop its head packet and reports each completed drop to
// the queue-length statistics block as a one-cycle event.
// Optional build macro HEADDROP_STATS_EN adds saturating drop counters;
// without it drop_cnt / drop_bytes are tied to zero.
// Ports:
//   clk, rstn                clock, async active-low reset
//   enable                   drops allowed (looked at only while idle)
//   bitmap, qempty           per-queue below-threshold / empty flags
//   drop_req, drop_port      request + one-hot victim to queue manager
//   drop_ack, drop_nak       queue manager response
//   drop_pkt_len             length of dropped packet, valid with ack
//   headdrop_out*            one-cycle drop event to statistics block
//   drop_timeout             one-cycle pulse when a request goes unanswered
//   drop_cnt, drop_bytes     saturating drop statistics (optional)
//
// state | meaning
// IDLE  | waiting for enable and a drop candidate
// REQ   | drop_req held for the latched victim, waiting for ack/nak/timeout
// GAP   | mandatory idle spacing after a finished or refused request
module headdrop_ctrl
    import headdrop_ctrl_pkg::*;
#(
    parameter int NPORT      = HD_NPORT_DEF,
    parameter int LEN_W      = HD_LEN_W_DEF,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [NPORT-1:0] bitmap,
    input  logic [NPORT-1:0] qempty,
    output logic             drop_req,
    output logic [3:0]       drop_port,
    input  logic             drop_ack,
    input  logic             drop_nak,
    input  logic [LEN_W-1:0] drop_pkt_len,
    output logic             headdrop_out,
    output logic [3:0]       headdrop_out_port,
    output logic [LEN_W-1:0] headdrop_pkt_len_out,
    output logic             drop_timeout,
    output logic [15:0]      drop_cnt,
    output logic [31:0]      drop_bytes
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
    // A zero gap skips GAP entirely so the next request can follow at M+2.
    localparam logic [1:0]    ST_AFTER_REQ = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    ptr_after;
    logic [3:0]       victim_bin;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    to_cnt;
    logic [NPORT-1:0] cand;
    logic [NPORT-1:0] grant;
    logic             grant_valid;
    logic [3:0]       grant_bin;

    assign cand      = ~bitmap & ~qempty;
    assign grant_bin = onehot_to_bin(4'(grant));
    assign ptr_after = (victim_bin == 4'(NPORT - 1)) ? '0 : PW'(victim_bin + 4'd1);

    headdrop_ctrl_rr_pick #(.N(NPORT), .PW(PW)) u_rr_pick (
        .cand  (cand),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= ST_IDLE;
            rr_ptr               <= '0;
            victim_bin           <= '0;
            gap_cnt              <= '0;
            to_cnt               <= '0;
            drop_req             <= 1'b0;
            drop_port            <= '0;
            headdrop_out         <= 1'b0;
            headdrop_out_port    <= '0;
            headdrop_pkt_len_out <= '0;
            drop_timeout         <= 1'b0;
        end else begin
            headdrop_out <= 1'b0;
            drop_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && grant_valid) begin
                        state      <= ST_REQ;
                        drop_req   <= 1'b1;
                        drop_port  <= 4'(grant);
                        victim_bin <= grant_bin;
                        to_cnt     <= TO_LOAD;
                    end
                end
                ST_REQ: begin
                    // ack has priority over a simultaneous nak and over the
                    // final timeout cycle.
                    if (drop_ack) begin
                        state                <= ST_AFTER_REQ;
                        gap_cnt              <= GAP_LOAD;
                        drop_req             <= 1'b0;
                        drop_port            <= '0;
                        rr_ptr               <= ptr_after;
                        headdrop_out         <= 1'b1;
                        headdrop_out_port    <= victim_bin;
                        headdrop_pkt_len_out <= drop_pkt_len;
                    end else if (drop_nak || to_cnt == '0) begin
                        state        <= ST_AFTER_REQ;
                        gap_cnt      <= GAP_LOAD;
                        drop_req     <= 1'b0;
                        drop_port    <= '0;
                        rr_ptr       <= ptr_after;
                        drop_timeout <= !drop_nak;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HEADDROP_STATS_EN
    logic [15:0] cnt_q;
    logic [31:0] bytes_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            bytes_q <= '0;
        end else if (headdrop_out) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (bytes_q > 32'hFFFF_FFFF - 32'(headdrop_pkt_len_out)) bytes_q <= '1;
            else bytes_q <= bytes_q + 32'(headdrop_pkt_len_out);
        end
    end

    assign drop_cnt   = cnt_q;
    assign drop_bytes = bytes_q;
`else
    assign drop_cnt   = '0;
    assign drop_bytes = '0;
`endif

endmodule

// File: tb/tb_headdrop_ctrl.sv
module tb_headdrop_ctrl;

    localparam int NPORT = 4;
    localparam int LEN_W = 11;
    localparam int GAP   = 4;
    localparam int TOUT  = 64;
`ifdef HEADDROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             enable;
    logic [NPORT-1:0] bitmap;
    logic [NPORT-1:0] qempty;
    logic             drop_req;
    logic [3:0]       drop_port;
    logic             drop_ack;
    logic             drop_nak;
    logic [LEN_W-1:0] drop_pkt_len;
    logic             headdrop_out;
    logic [3:0]       headdrop_out_port;
    logic [LEN_W-1:0] headdrop_pkt_len_out;
    logic             drop_timeout;
    logic [15:0]      drop_cnt;
    logic [31:0]      drop_bytes;

    headdrop_ctrl #(.NPORT(NPORT), .LEN_W(LEN_W), .GAP_CYCLES(GAP), .TIMEOUT(TOUT)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .enable               (enable),
        .bitmap               (bitmap),
        .qempty               (qempty),
        .drop_req             (drop_req),
        .drop_port            (drop_port),
        .drop_ack             (drop_ack),
        .drop_nak             (drop_nak),
        .drop_pkt_len         (drop_pkt_len),
        .headdrop_out         (headdrop_out),
        .headdrop_out_port    (headdrop_out_port),
        .headdrop_pkt_len_out (headdrop_pkt_len_out),
        .drop_timeout         (drop_timeout),
        .drop_cnt             (drop_cnt),
        .drop_bytes           (drop_bytes)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: transaction view with timestamps.
    int          cyc;
    bit          m_busy;
    int          m_victim;
    int          m_age;
    int          m_ptr;
    int          m_accept;
    bit          m_ev;
    bit          m_to;
    int          m_ev_port;
    logic [10:0] m_len;
    logic [15:0] m_cnt;
    logic [31:0] m_bytes;

    int ev_count;
    int to_count;
    bit prev_hd;

    typedef struct {
        logic [3:0]  bitmap;
        logic        ack;
        logic [10:0] len;
        logic        exp_req;
        logic [3:0]  exp_port;
        logic        exp_ev;
        logic [3:0]  exp_ev_port;
        logic [10:0] exp_len;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_busy = 0; m_victim = 0; m_age = 0; m_ptr = 0; m_accept = 0;
        m_ev = 0; m_to = 0; m_ev_port = 0; m_len = '0; m_cnt = '0; m_bytes = '0;
        prev_hd = 0;
    endtask

    // Advance one clock: predict, clock, compare.
    task automatic step();
        logic [3:0] cand;
        longint     sum;
        cand = ~bitmap & ~qempty;
        if (m_ev) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            sum = longint'(m_bytes) + longint'(m_len);
            m_bytes = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sum);
        end
        m_ev = 0;
        m_to = 0;
        if (m_busy) begin
            m_age++;
            if (drop_ack || drop_nak || m_age == TOUT) begin
                m_busy   = 0;
                m_accept = cyc + 1 + GAP;
                m_ptr    = (m_victim + 1) % NPORT;
                if (drop_ack) begin
                    m_ev      = 1;
                    m_ev_port = m_victim;
                    m_len     = drop_pkt_len;
                end else if (!drop_nak) begin
                    m_to = 1;
                end
            end
        end else if (cyc >= m_accept && enable && cand != 4'd0) begin
            for (int k = NPORT - 1; k >= 0; k--) begin
                if (((cand >> ((m_ptr + k) % NPORT)) & 4'd1) != 4'd0) m_victim = (m_ptr + k) % NPORT;
            end
            m_busy = 1;
            m_age  = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("drop_req", 32'(drop_req), 32'(m_busy));
        if (m_busy) chk("drop_port", 32'(drop_port), 32'(1) << m_victim);
        chk("headdrop_out", 32'(headdrop_out), 32'(m_ev));
        if (m_ev) chk("event_port", 32'(headdrop_out_port), 32'(m_ev_port));
        chk("event_len", 32'(headdrop_pkt_len_out), 32'(m_len));
        chk("drop_timeout", 32'(drop_timeout), 32'(m_to));
        chk("drop_cnt", 32'(drop_cnt), STATS ? 32'(m_cnt) : 32'd0);
        chk("drop_bytes", drop_bytes, STATS ? m_bytes : 32'd0);
        if (headdrop_out) begin
            ev_count++;
            chk("back_to_back_event", 32'(prev_hd), 32'd0);
        end
        if (drop_timeout) to_count++;
        prev_hd = headdrop_out;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        enable = 1'b0; bitmap = '1; qempty = '0;
        drop_ack = 1'b0; drop_nak = 1'b0; drop_pkt_len = '0;
        #1;
        chk("rst_drop_req", 32'(drop_req), 32'd0);
        chk("rst_drop_port", 32'(drop_port), 32'd0);
        chk("rst_headdrop_out", 32'(headdrop_out), 32'd0);
        chk("rst_event_len", 32'(headdrop_pkt_len_out), 32'd0);
        chk("rst_timeout", 32'(drop_timeout), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (drop_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_req", 32'(drop_req), 32'd1);
    endtask

    task automatic ack_once(input logic [10:0] len);
        drop_ack = 1'b1;
        drop_pkt_len = len;
        step();
        drop_ack = 1'b0;
    endtask

    initial begin
        int ev_base;
        int hi;
        int to_base;
        int mute;
        int r;
        logic [10:0] lens[3];

        ev_count = 0;
        to_count = 0;
        model_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: table-driven single drop on port 2, then gap spacing.
        tbl[0] = '{4'b1011, 1'b0, 11'd0,   1'b1, 4'b0100, 1'b0, 4'd0, 11'd0};
        tbl[1] = '{4'b1011, 1'b0, 11'd0,   1'b1, 4'b0100, 1'b0, 4'd0, 11'd0};
        tbl[2] = '{4'b1011, 1'b0, 11'd0,   1'b1, 4'b0100, 1'b0, 4'd0, 11'd0};
        tbl[3] = '{4'b1011, 1'b1, 11'd300, 1'b0, 4'b0000, 1'b1, 4'd2, 11'd300};
        tbl[4] = '{4'b1011, 1'b0, 11'd0,   1'b0, 4'b0000, 1'b0, 4'd0, 11'd300};
        tbl[5] = '{4'b1011, 1'b0, 11'd0,   1'b0, 4'b0000, 1'b0, 4'd0, 11'd300};
        tbl[6] = '{4'b1011, 1'b0, 11'd0,   1'b0, 4'b0000, 1'b0, 4'd0, 11'd300};
        tbl[7] = '{4'b1011, 1'b0, 11'd0,   1'b0, 4'b0000, 1'b0, 4'd0, 11'd300};
        tbl[8] = '{4'b1011, 1'b0, 11'd0,   1'b1, 4'b0100, 1'b0, 4'd0, 11'd300};
        tbl[9] = '{4'b1011, 1'b1, 11'd5,   1'b0, 4'b0000, 1'b1, 4'd2, 11'd5};
        do_reset();
        enable = 1'b1; qempty = '0;
        for (int i = 0; i < 10; i++) begin
            bitmap = tbl[i].bitmap;
            drop_ack = tbl[i].ack;
            drop_pkt_len = tbl[i].len;
            step();
            chk("t1_req", 32'(drop_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk("t1_port", 32'(drop_port), 32'(tbl[i].exp_port));
            chk("t1_event", 32'(headdrop_out), 32'(tbl[i].exp_ev));
            if (tbl[i].exp_ev) chk("t1_event_port", 32'(headdrop_out_port), 32'(tbl[i].exp_ev_port));
            chk("t1_len", 32'(headdrop_pkt_len_out), 32'(tbl[i].exp_len));
        end
        drop_ack = 1'b0;

        // Test 2: all queues over threshold, round robin 0,1,2,3,0.
        do_reset();
        enable = 1'b1; bitmap = 4'b0000; qempty = '0;
        ev_base = ev_count;
        for (int k = 0; k < 5; k++) begin
            wait_req(20);
            chk("t2_victim", 32'(drop_port), 32'(1) << (k % 4));
            ack_once(11'd64);
        end
        bitmap = 4'hF;
        repeat (8) step();
        chk("t2_events", 32'(ev_count - ev_base), 32'd5);

        // Test 3: nak on port 1, next victim starts at port 2.
        do_reset();
        enable = 1'b1; bitmap = 4'b1101; qempty = '0;
        ev_base = ev_count;
        wait_req(20);
        chk("t3_victim", 32'(drop_port), 32'b0010);
        drop_nak = 1'b1;
        step();
        drop_nak = 1'b0;
        chk("t3_no_event", 32'(ev_count - ev_base), 32'd0);
        bitmap = 4'b0000;
        wait_req(20);
        chk("t3_next_victim", 32'(drop_port), 32'b0100);
        ack_once(11'd7);

        // Test 4: timeout after TIMEOUT cycles, late ack ignored.
        do_reset();
        enable = 1'b1; bitmap = 4'b1110; qempty = '0;
        wait_req(20);
        ev_base = ev_count;
        to_base = to_count;
        hi = 0;
        while (drop_req && hi < 200) begin
            hi++;
            step();
        end
        chk("t4_req_cycles", 32'(hi), 32'(TOUT));
        chk("t4_timeout_pulse", 32'(to_count - to_base), 32'd1);
        bitmap = 4'hF;
        repeat (9) step();
        ack_once(11'd99);
        repeat (3) step();
        chk("t4_late_ack_events", 32'(ev_count - ev_base), 32'd0);
        chk("t4_timeout_once", 32'(to_count - to_base), 32'd1);

        // Test 5: reset while requesting.
        do_reset();
        enable = 1'b1; bitmap = 4'b1011; qempty = '0;
        ev_base = ev_count;
        wait_req(20);
        do_reset();
        chk("t5_no_event", 32'(ev_count - ev_base), 32'd0);
        enable = 1'b1; bitmap = 4'b1110; qempty = '0;
        wait_req(20);
        chk("t5_first_victim", 32'(drop_port), 32'b0001);
        ack_once(11'd1);

        // Test 6: statistics counters.
        do_reset();
        enable = 1'b1; bitmap = 4'b1110; qempty = '0;
        lens[0] = 11'd100; lens[1] = 11'd200; lens[2] = 11'd1500;
        for (int k = 0; k < 3; k++) begin
            wait_req(20);
            ack_once(lens[k]);
        end
        bitmap = 4'hF;
        step();
        chk("t6_drop_cnt", 32'(drop_cnt), STATS ? 32'd3 : 32'd0);
        chk("t6_drop_bytes", drop_bytes, STATS ? 32'd1800 : 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        mute = 0;
        for (int n = 0; n < 3000; n++) begin
            bitmap = 4'($urandom);
            qempty = 4'($urandom) & 4'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            drop_pkt_len = 11'($urandom_range(0, 2047));
            drop_ack = 1'b0;
            drop_nak = 1'b0;
            if (mute > 0) mute--;
            else if ($urandom_range(0, 199) == 0) mute = 80;
            if (drop_req && mute == 0) begin
                r = int'($urandom_range(0, 9));
                drop_ack = (r < 3) || (r == 4);
                drop_nak = (r == 3) || (r == 4);
            end else if (!drop_req) begin
                drop_ack = ($urandom_range(0, 19) == 0);
                drop_nak = ($urandom_range(0, 19) == 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
